// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Single-outstanding instruction fetch stage. It issues one instruction-memory
//   read at the current PC, latches the returned word, and holds it for decode.
//   When decode consumes the word, the PC moves to PC+4 or to the branch target.
//
// Optional feature (macro IFU_HALT_ON_ZERO_EN):
//   When defined, a fetched word of 32'h0 sends the unit to HALT. Only reset
//   leaves HALT. When undefined, 32'h0 is an ordinary instruction and o_halted
//   is tied to 0.
//
// Parameters
//   RESET_PC       PC value loaded on reset
// Ports
//   i_clk          clock; all state updates on its rising edge
//   i_rst          synchronous active-high reset
//   o_imemReq      instruction-memory read request
//   o_imemAddr     read address (current PC)
//   i_imemAck      i_imemData is valid for the current request
//   i_imemData     fetched instruction word
//   i_advance      decode consumed the held instruction
//   i_PCSrc        take the branch target as next PC
//   i_branchTarget branch target address (low two bits ignored)
//   o_instr        latched instruction word
//   o_opCode       o_instr[31:21]
//   o_PC           address of o_instr
//   o_instrValid   o_instr/o_opCode/o_PC are valid
//   o_halted       unit is halted
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [63:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  input  logic        i_advance,
  input  logic        i_PCSrc,
  input  logic [63:0] i_branchTarget,
  output logic [31:0] o_instr,
  output logic [10:0] o_opCode,
  output logic [63:0] o_PC,
  output logic        o_instrValid,
  output logic        o_halted
);

`ifdef IFU_HALT_ON_ZERO_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1} state_t;
`endif

  state_t      state;
  state_t      next_state;
  logic [63:0] pc;
  logic [31:0] instr;

  // Instruction addresses are word aligned, so the low bits of the target
  // carry no information.
  logic        unused_tgt_bits;
  assign unused_tgt_bits = ^i_branchTarget[1:0];

  // A word is accepted only while a request is outstanding. Acks that arrive
  // in HOLD or HALT are stale and are dropped here.
  logic take_ack;
  logic take_adv;
  assign take_ack = (state == FETCH) && i_imemAck;
  assign take_adv = (state == HOLD) && i_advance;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (i_imemAck) begin
`ifdef IFU_HALT_ON_ZERO_EN
          if (i_imemData == 32'h0) next_state = HALT;
          else                     next_state = HOLD;
`else
          next_state = HOLD;
`endif
        end
      end
      HOLD: if (i_advance) next_state = FETCH;
`ifdef IFU_HALT_ON_ZERO_EN
      HALT: next_state = HALT;
`endif
      default: next_state = FETCH;
    endcase
  end

  // Datapath: PC and the latched instruction word. Branch select and target
  // are looked at only on the advance that ends a HOLD.
  // Under HALT the PC is never written again, so it stays frozen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      if (take_ack) instr <= i_imemData;
      if (take_adv) pc    <= i_PCSrc ? {i_branchTarget[63:2], 2'b00} : pc + 64'd4;
    end
  end

  // Output logic
  always_comb begin
    // The request is masked by i_rst so that it drops while reset is held.
    // It rises in the first cycle after reset releases. A fetch that was in
    // flight when reset arrived is therefore abandoned and reissued from
    // RESET_PC.
    o_imemReq    = (state == FETCH) && !i_rst;
    o_imemAddr   = pc;
    o_instr      = instr;
    o_opCode     = instr[31:21];
    o_PC         = pc;
    o_instrValid = (state == HOLD);
`ifdef IFU_HALT_ON_ZERO_EN
    o_halted     = (state == HALT);
`else
    o_halted     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        adv;
  logic        pcsrc;
  logic [63:0] tgt;
  logic [31:0] instr;
  logic [10:0] opc;
  logic [63:0] pcv;
  logic        vld;
  logic        halted;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imemReq(req), .o_imemAddr(addr),
    .i_imemAck(ack), .i_imemData(data),
    .i_advance(adv), .i_PCSrc(pcsrc), .i_branchTarget(tgt),
    .o_instr(instr), .o_opCode(opc), .o_PC(pcv),
    .o_instrValid(vld), .o_halted(halted)
  );

  always #5 clk = ~clk;

  // Samples and drives are placed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // Deliver one word while in FETCH. Afterwards the unit is in HOLD.
  task automatic give(input logic [31:0] w);
    ack = 1'b1; data = w;
    step();
    ack = 1'b0;
  endtask

  // One-cycle advance pulse while in HOLD.
  task automatic advance(input logic src, input logic [63:0] t);
    adv = 1'b1; pcsrc = src; tgt = t;
    step();
    adv = 1'b0; pcsrc = 1'b0; tgt = 64'h0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; data = 32'h0; adv = 1'b0; pcsrc = 1'b0; tgt = 64'h0;
    step(); step();
    chk("rst_req",    {63'd0, req},    64'd0);
    chk("rst_vld",    {63'd0, vld},    64'd0);
    chk("rst_instr",  {32'd0, instr},  64'd0);
    chk("rst_pc",     pcv,             64'h0);
    chk("rst_halted", {63'd0, halted}, 64'd0);

    // The first cycle after reset releases must already request PC=RESET_PC.
    rst = 1'b0; #1;
    chk("first_req",  {63'd0, req}, 64'd1);
    chk("first_addr", addr,         64'h0);
    step();
    chk("req_wait", {63'd0, req}, 64'd1);

    give(32'h8B020020);
    chk("hold_vld",    {63'd0, vld},   64'd1);
    chk("hold_opcode", {53'd0, opc},   64'h458);
    chk("hold_pc",     pcv,            64'h0);
    chk("hold_instr",  {32'd0, instr}, 64'h8B020020);
    chk("hold_noreq",  {63'd0, req},   64'd0);

    // A stray ack in HOLD must not overwrite the held word.
    ack = 1'b1; data = 32'hDEADBEEF; step(); ack = 1'b0; step();
    chk("hold_stale_ack", {32'd0, instr}, 64'h8B020020);
    chk("hold_stable_pc", pcv,            64'h0);

    // Walk sequentially to PC=0x10.
    advance(1'b0, 64'h0);
    chk("seq_addr4", addr,         64'h4);
    chk("seq_req",   {63'd0, req}, 64'd1);
    chk("seq_vld",   {63'd0, vld}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      give(32'h11111111);
      advance(1'b0, 64'h0);
    end
    give(32'h22222222);
    chk("pc10", pcv, 64'h10);
    advance(1'b0, 64'h0);
    chk("pc14_addr", addr,         64'h14);
    chk("pc14_req",  {63'd0, req}, 64'd1);
    chk("pc14_vld",  {63'd0, vld}, 64'd0);

    // An advance and branch presented during FETCH must be ignored.
    adv = 1'b1; pcsrc = 1'b1; tgt = 64'h500; step();
    adv = 1'b0; pcsrc = 1'b0; tgt = 64'h0;
    chk("fetch_adv_ign", addr, 64'h14);
    give(32'h33333333);
    advance(1'b1, 64'h103);
    chk("branch_addr", addr,         64'h100);
    chk("branch_req",  {63'd0, req}, 64'd1);

    // Withhold the ack for 5 cycles while toggling advance.
    for (int i = 0; i < 5; i++) begin
      adv = i[0];
      step();
      chk("stall_req",  {63'd0, req}, 64'd1);
      chk("stall_addr", addr,         64'h100);
    end
    adv = 1'b0;

    // Wrap modulo 2^64. The target's low bits are masked.
    give(32'h44444444);
    advance(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_pre", addr, 64'hFFFF_FFFF_FFFF_FFFC);
    give(32'h55555555);
    chk("wrap_pc_hold", pcv, 64'hFFFF_FFFF_FFFF_FFFC);
    advance(1'b0, 64'h0);
    chk("wrap_addr", addr, 64'h0);

    // Reset while a fetch is pending at 0x40, with a stale ack during reset.
    give(32'h66666666);
    advance(1'b1, 64'h40);
    chk("pend40_addr", addr,         64'h40);
    chk("pend40_req",  {63'd0, req}, 64'd1);
    rst = 1'b1; ack = 1'b1; data = 32'h12345678; #1;
    chk("rst_req_drop", {63'd0, req}, 64'd0);
    step();
    chk("rst2_req",   {63'd0, req},   64'd0);
    chk("rst2_vld",   {63'd0, vld},   64'd0);
    chk("rst2_pc",    pcv,            64'h0);
    chk("rst2_instr", {32'd0, instr}, 64'h0);
    step();
    chk("rst3_vld", {63'd0, vld}, 64'd0);
    rst = 1'b0; ack = 1'b0; data = 32'h0; #1;
    chk("rerq_req",  {63'd0, req}, 64'd1);
    chk("rerq_addr", addr,         64'h0);

    // In the default build, a zero word is an ordinary instruction.
    step();
    give(32'h0);
    chk("zero_vld",    {63'd0, vld},    64'd1);
    chk("zero_opcode", {53'd0, opc},    64'h0);
    chk("zero_halted", {63'd0, halted}, 64'd0);
    advance(1'b0, 64'h0);
    chk("zero_next_addr", addr,         64'h4);
    chk("zero_next_req",  {63'd0, req}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
